// File: rtl/gray_stim_seq_if.sv
// gray_stim_seq_if: stimulus bundle between the Gray sequencer and its user.
// master: the sequencer (takes start, drives a/b/c, idx, step, busy, done).
// slave: the user (drives start, observes everything else).
interface gray_stim_seq_if;
   logic       start;
   logic       a;
   logic       b;
   logic       c;
   logic [2:0] idx;
   logic       step;
   logic       busy;
   logic       done;
   modport master (input start, output a, b, c, idx, step, busy, done);
   modport slave (output start, input a, b, c, idx, step, busy, done);
endinterface

// File: rtl/gray_stim_seq.sv
// gray_stim_seq: walks {a,b,c} through the 3-bit Gray order, DWELL cycles per vector, LOOPS passes, then settles on 000.
// Ports: clk, rst (sync, active-high), bus (master modport: start in; a,b,c,idx,step,busy,done out, all registered).
module gray_stim_seq #(
   parameter int DWELL = 50,
   parameter int LOOPS = 1
) (
   input logic            clk,
   input logic            rst,
   gray_stim_seq_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  loop_q, loop_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  abc_q, abc_d;
   logic        step_q, step_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        tc;
   assign tc = cnt_q == 16'(DWELL - 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = tc ? 16'd0 : cnt_q + 16'd1;
      loop_d  = loop_q;
      idx_d   = idx_q;
      step_d  = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = 16'd0;
            loop_d = 8'd0;
            idx_d  = 3'd0;
            if (bus.start) begin
               state_d = RUN;
               step_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         RUN: if (tc) begin
            step_d = 1'b1;
            idx_d  = idx_q + 3'd1;
            // After vector 7 the index wraps to 0 either for another pass or for the settle vector.
            if (idx_q == 3'd7) begin
               if (loop_q == 8'(LOOPS - 1)) state_d = SETTLE;
               else loop_d = loop_q + 8'd1;
            end
         end
         SETTLE: if (tc) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      abc_d = idx_d ^ (idx_d >> 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         loop_q  <= '0;
         idx_q   <= '0;
         abc_q   <= '0;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         loop_q  <= loop_d;
         idx_q   <= idx_d;
         abc_q   <= abc_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign bus.a    = abc_q[2];
   assign bus.b    = abc_q[1];
   assign bus.c    = abc_q[0];
   assign bus.idx  = idx_q;
   assign bus.step = step_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_gray_stim_seq.sv
// tb_gray_stim_seq: directed checks of gray_stim_seq with DWELL=4/LOOPS=1, DWELL=1/LOOPS=2 and DWELL=2/LOOPS=1 instances.
module tb_gray_stim_seq;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   gray_stim_seq_if i4 ();
   gray_stim_seq_if i1 ();
   gray_stim_seq_if i2 ();
   gray_stim_seq #(.DWELL(4), .LOOPS(1)) u4 (.clk(clk), .rst(rst), .bus(i4));
   gray_stim_seq #(.DWELL(1), .LOOPS(2)) u1 (.clk(clk), .rst(rst), .bus(i1));
   gray_stim_seq #(.DWELL(2), .LOOPS(1)) u2 (.clk(clk), .rst(rst), .bus(i2));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [8:0] e(input int v, input logic st, input logic bs, input logic dn);
      logic [2:0] i;
      i = 3'(v % 8);
      return {i ^ (i >> 1), i, st, bs, dn};
   endfunction
   function automatic logic [8:0] s4();
      return {i4.a, i4.b, i4.c, i4.idx, i4.step, i4.busy, i4.done};
   endfunction
   function automatic logic [8:0] s1();
      return {i1.a, i1.b, i1.c, i1.idx, i1.step, i1.busy, i1.done};
   endfunction
   function automatic logic [8:0] s2();
      return {i2.a, i2.b, i2.c, i2.idx, i2.step, i2.busy, i2.done};
   endfunction
   task automatic run4(input bit lock);
      int st;
      st = 0;
      i4.start = 1'b1;
      tick();
      i4.start = 1'b0;
      for (int k = 0; k < 36; k++) begin
         chk(lock ? "lock4" : "run4", 32'(s4()), 32'(e(k / 4, k % 4 == 0, 1'b1, 1'b0)));
         st += int'(i4.step);
         i4.start = lock && (k == 5 || k == 35);
         tick();
      end
      i4.start = 1'b0;
      chk("steps4", st, 9);
      chk("done4", 32'(s4()), 32'(e(0, 1'b0, 1'b0, 1'b1)));
      tick();
      chk("after4", 32'(s4()), 0);
   endtask
   initial begin
      int nd;
      logic [2:0] prev, cur;
      rst = 1'b1;
      i4.start = 1'b1;
      i1.start = 1'b1;
      i2.start = 1'b1;
      tick();
      chk("rst4", 32'(s4()), 0);
      chk("rst1", 32'(s1()), 0);
      chk("rst2", 32'(s2()), 0);
      tick();
      tick();
      chk("rst_hold4", 32'(s4()), 0);
      rst = 1'b0;
      i4.start = 1'b0;
      i1.start = 1'b0;
      i2.start = 1'b0;
      tick();
      chk("idle4", 32'(s4()), 0);
      run4(1'b0);
      run4(1'b1);
      i4.start = 1'b1;
      tick();
      i4.start = 1'b0;
      repeat (20) tick();
      chk("mid_idx5", 32'(i4.idx), 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst", 32'(s4()), 0);
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         nd += int'(i4.done) + int'(i4.busy);
         tick();
      end
      chk("mid_quiet", nd, 0);
      i4.start = 1'b1;
      tick();
      i4.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("restart4", 32'(s4()), 32'(e(k / 4, k % 4 == 0, 1'b1, 1'b0)));
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      i1.start = 1'b1;
      tick();
      i1.start = 1'b0;
      prev = 3'd0;
      for (int k = 0; k < 17; k++) begin
         cur = {i1.a, i1.b, i1.c};
         chk("d1", 32'(s1()), 32'(e(k == 16 ? 0 : k % 8, 1'b1, 1'b1, 1'b0)));
         if (k > 0) chk("gray_adj", $countones(prev ^ cur), 1);
         prev = cur;
         tick();
      end
      chk("d1_done", 32'(s1()), 32'(e(0, 1'b0, 1'b0, 1'b1)));
      i2.start = 1'b1;
      tick();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 18; k++) begin
            chk("b2b", 32'(s2()), 32'(e(k / 2, k % 2 == 0, 1'b1, 1'b0)));
            tick();
         end
         chk("b2b_gap", 32'({i2.a, i2.b, i2.c, i2.idx, i2.busy, i2.done}), 32'b0000001);
         if (r == 2) i2.start = 1'b0;
         tick();
      end
      chk("b2b_idle", 32'(s2()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
